// File: rtl/snn_neuron_fire_if.sv
// Handshake bundle between the weighted-sum adder and the neuron firing stage.
// The master side drives sums in; the slave side (neuron) returns the result strobe.
interface snn_neuron_fire_if #(
   parameter int p_width = 16
);
   logic                 i_valid;
   logic [p_width+3:0]   i_sum;
   logic                 i_learn;
   logic                 o_ready;
   logic                 o_valid;
   logic                 o_spike;
   logic [p_width+3:0]   o_potential;
   logic [p_width+3:0]   o_threshold;

   modport master (
      output i_valid, i_sum, i_learn,
      input  o_ready, o_valid, o_spike, o_potential, o_threshold
   );

   modport slave (
      input  i_valid, i_sum, i_learn,
      output o_ready, o_valid, o_spike, o_potential, o_threshold
   );
endinterface

// File: rtl/snn_neuron_fire.sv
// Neuron firing stage: registers a dot-product sum, compares it to an adaptive threshold,
// optionally adapts the threshold and enters refractory. SPIKE_COUNT_EN adds a spike counter.
module snn_neuron_fire #(
   parameter int p_width     = 16,
   parameter int p_thr_init  = 1000,
   parameter int p_thr_min   = 8,
   parameter int p_eta_shift = 3,
   parameter int p_refr      = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_decay,
`ifdef SPIKE_COUNT_EN
   input  logic                  i_cnt_clr,
   output logic [15:0]           o_spike_cnt,
`endif
   snn_neuron_fire_if.slave      bus
);
   localparam int W         = p_width + 4;
   localparam int CW        = (p_refr > 1) ? $clog2(p_refr) : 1;
   localparam int REFR_LOAD = (p_refr > 0) ? p_refr - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPARE,
      ST_ADAPT,
      ST_REFRACT
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   potential_q, potential_d;
   logic [W-1:0]   threshold_q, threshold_d;
   logic           learn_q, learn_d;
   logic           valid_q, valid_d;
   logic           spike_q, spike_d;
   logic           decay_pend_q, decay_pend_d;
   logic [CW-1:0]  refr_cnt_q, refr_cnt_d;
   logic           fire;

   // Step is at least 1 so small thresholds still move; result never drops below the floor.
   function automatic logic [W-1:0] decay_apply(input logic [W-1:0] thr);
      logic [W-1:0] step;
      logic [W-1:0] res;
      if (thr <= W'(p_thr_min)) begin
         res = thr;
      end else begin
         step = thr >> p_eta_shift;
         if (step == '0) begin
            step = W'(1);
         end
         res = thr - step;
         if (res < W'(p_thr_min)) begin
            res = W'(p_thr_min);
         end
      end
      return res;
   endfunction

   assign fire = (potential_q >= threshold_q);

   always_comb begin
      state_d      = state_q;
      potential_d  = potential_q;
      threshold_d  = threshold_q;
      learn_d      = learn_q;
      valid_d      = 1'b0;
      spike_d      = 1'b0;
      decay_pend_d = decay_pend_q;
      refr_cnt_d   = refr_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_valid) begin
               potential_d = bus.i_sum;
               learn_d     = bus.i_learn;
               state_d     = ST_COMPARE;
            end
            if (decay_pend_q || i_decay) begin
               threshold_d = decay_apply(threshold_q);
            end
            decay_pend_d = 1'b0;
         end
         ST_COMPARE: begin
            valid_d = 1'b1;
            spike_d = fire;
            state_d = (fire && learn_q) ? ST_ADAPT : ST_IDLE;
            if (i_decay) begin
               threshold_d = decay_apply(threshold_q);
            end
         end
         ST_ADAPT: begin
            // A decay here would race the adaptation, so it is deferred to the next IDLE edge.
            threshold_d = threshold_q + ((potential_q - threshold_q) >> p_eta_shift);
            if (i_decay) begin
               decay_pend_d = 1'b1;
            end
            refr_cnt_d = CW'(REFR_LOAD);
            state_d    = (p_refr > 0) ? ST_REFRACT : ST_IDLE;
         end
         ST_REFRACT: begin
            if (i_decay) begin
               threshold_d = decay_apply(threshold_q);
            end
            if (refr_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               refr_cnt_d = refr_cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         potential_q  <= '0;
         threshold_q  <= W'(p_thr_init);
         learn_q      <= 1'b0;
         valid_q      <= 1'b0;
         spike_q      <= 1'b0;
         decay_pend_q <= 1'b0;
         refr_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         potential_q  <= potential_d;
         threshold_q  <= threshold_d;
         learn_q      <= learn_d;
         valid_q      <= valid_d;
         spike_q      <= spike_d;
         decay_pend_q <= decay_pend_d;
         refr_cnt_q   <= refr_cnt_d;
      end
   end

   assign bus.o_ready     = (state_q == ST_IDLE);
   assign bus.o_valid     = valid_q;
   assign bus.o_spike     = spike_q;
   assign bus.o_potential = potential_q;
   assign bus.o_threshold = threshold_q;

`ifdef SPIKE_COUNT_EN
   logic [15:0] spike_cnt_q, spike_cnt_d;

   always_comb begin
      spike_cnt_d = spike_cnt_q;
      if (i_cnt_clr) begin
         spike_cnt_d = '0;
      end else if (spike_q && (spike_cnt_q != '1)) begin
         spike_cnt_d = spike_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         spike_cnt_q <= '0;
      end else begin
         spike_cnt_q <= spike_cnt_d;
      end
   end

   assign o_spike_cnt = spike_cnt_q;
`endif
endmodule

// File: doc/snn_neuron_fire.md
Name: snn_neuron_fire

Overview:
Neuron firing stage that sits directly downstream of the 10-input weighted-sum adder. It registers one dot-product sum per handshake and compares it against a per-neuron adaptive threshold. It emits a one-cycle spike and result strobe, and optionally adapts the threshold (ODESA-style) before a refractory period. It also applies externally requested threshold decay.

Parameters:
p_width, 16, adder operand width; the sum and threshold are p_width+4 bits wide.
p_thr_init, 1000, threshold value loaded at reset.
p_thr_min, 8, floor for threshold decay.
p_eta_shift, 3, learning/decay rate as a right-shift amount.
p_refr, 4, refractory cycles after a learned spike; 0 means no refractory period.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_valid  in  1  sum valid from the adder stage.
i_sum  in  p_width+4  unsigned weighted sum.
o_ready  out  1  high when a sum can be accepted.
i_learn  in  1  sampled at accept; enables threshold adaptation on a spike.
i_decay  in  1  single-cycle decay request.
o_valid  out  1  one-cycle result strobe.
o_spike  out  1  one-cycle spike, only ever high together with o_valid.
o_potential  out  p_width+4  registered sum of the last accepted sample.
o_threshold  out  p_width+4  current threshold.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, o_ready=1, o_valid=0, o_spike=0, o_potential=0.
  - o_threshold=p_thr_init; decay-pending flag cleared; learn latch cleared.
  - Reset asserted mid-operation aborts any state with no partial threshold update.
- States: IDLE, COMPARE, ADAPT, REFRACT.
- o_ready=1 only in IDLE.
- IDLE:
  - Accept occurs when i_valid&&o_ready on an edge: i_sum goes to o_potential, i_learn is latched, next state=COMPARE.
  - i_valid outside IDLE is ignored; the sample is dropped, not queued.
- COMPARE (one cycle): on the exiting edge, o_valid<=1 and o_spike<=(o_potential>=o_threshold). Comparison is unsigned and equality fires.
  - Spike with learn latched: next state=ADAPT.
  - Otherwise: next state=IDLE.
  - Latency: o_valid is high in the cycle two edges after the accept edge; o_valid and o_spike are high for exactly one cycle.
- ADAPT (one cycle):
  - o_threshold <= o_threshold + ((o_potential - o_threshold) >> p_eta_shift).
  - The difference is non-negative and the result is at most o_potential, so no overflow is possible.
  - Next state=REFRACT if p_refr>0, else IDLE.
- REFRACT: a counter loads p_refr-1 on entry and decrements each cycle; the state exits to IDLE after exactly p_refr cycles.
- Decay rule (i_decay=1):
  - step = max(1, o_threshold >> p_eta_shift).
  - o_threshold <= max(p_thr_min, o_threshold - step).
  - If o_threshold is already at or below p_thr_min, it is unchanged.
  - Decay in IDLE, COMPARE or REFRACT is applied on that edge.
  - Decay arriving in ADAPT, or simultaneously with the ADAPT update, sets the pending flag. The pending decay is applied on the first edge in the next IDLE cycle, then cleared.
  - Multiple decay pulses while pending collapse to one.
  - A decay applied in COMPARE does not affect that cycle's comparison, which uses the pre-edge threshold.
- An accept and a pending-decay application in the same IDLE edge are both performed.

Optional Feature:
Macro SPIKE_COUNT_EN.
- Defined:
  - Adds input i_cnt_clr (1) and output o_spike_cnt (16).
  - o_spike_cnt increments on every o_spike and saturates at 16'hFFFF.
  - i_cnt_clr synchronously clears it; clear wins over a simultaneous increment.
  - Reset value is 0.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
All scenarios use p_width=16, p_thr_init=1000, p_thr_min=8, p_eta_shift=3, p_refr=4.
1. Assert and release reset mid-cycle -> o_ready=1, o_valid=0, o_spike=0, o_potential=0, o_threshold=1000 immediately on assertion (async).
2. i_sum=900, i_learn=0 -> o_valid=1, o_spike=0 two edges after accept; o_threshold stays 1000; o_ready is high again in the following cycle. Repeat with i_sum=1000 -> o_spike=1, threshold unchanged.
3. i_sum=1800, i_learn=1 -> spike, then o_threshold=1100; o_ready low for exactly 4 REFRACT cycles; i_valid pulses during REFRACT are ignored and produce no o_valid.
4. Decay in IDLE with threshold 1000 -> 875. Threshold 9 -> 8. Threshold 8 -> stays 8.
5. Decay asserted in the ADAPT cycle of scenario 3 -> o_threshold=1100 after ADAPT, then 963 on the first IDLE edge after REFRACT. Assert i_rst_n=0 during REFRACT -> immediate IDLE, o_threshold=1000, pending flag cleared.
6. SPIKE_COUNT_EN defined: three spikes give o_spike_cnt=3. i_cnt_clr coinciding with a spike gives 0. Preload near saturation: the count holds at 16'hFFFF.
